// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver: assembles MSB-first words from a strobed bit stream
// and presents them on a one-deep valid/ready output register with sticky drop flag.
module serial_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             carga,
    input  logic             shift,
    input  logic             sin,
    input  logic             ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt;
    logic             overflow_nxt;
    logic [WIDTH-1:0] word_c;

    assign word_c = {acc[WIDTH-2:0], sin};

    // Next-state: frame realign beats bit capture; handshake consumption applies independently.
    always_comb begin
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        data_nxt     = dataOut;
        valid_nxt    = valid;
        overflow_nxt = overflow;

        if (valid && ready) begin
            valid_nxt = 1'b0;
        end

        if (carga) begin
            acc_nxt = '0;
            cnt_nxt = '0;
        end else if (shift) begin
            if (cnt == LAST) begin
                acc_nxt = '0;
                cnt_nxt = '0;
                if (!valid || ready) begin
                    data_nxt  = word_c;
                    valid_nxt = 1'b1;
                end else begin
                    overflow_nxt = 1'b1;
                end
            end else begin
                acc_nxt = word_c;
                cnt_nxt = cnt + CNTW'(1);
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            acc      <= '0;
            cnt      <= '0;
            dataOut  <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            dataOut  <= data_nxt;
            valid    <= valid_nxt;
            busy     <= (cnt_nxt != '0);
            overflow <= overflow_nxt;
        end
    end

endmodule
